spi_regfile_peripheral: RTL and testbench

Parametrised SPI (mode 0) peripheral that gives an external controller write and optional read access to a bank of `NUM_REGS` configuration registers, each `DATA_W` bits. It sits between the chip's SPI pins and the PWM/output-enable logic. It oversamples the SPI pins on the system clock and commits a write only when a complete, well-formed frame ends. It also reports malformed or out-of-range frames.

---
 rtl/spi_regfile_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 43 ++++
 rtl/spi_regfile_peripheral.sv | 184 ++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Purpose : shared types and constants for the SPI register-file peripheral.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: frame state enum, R/W bit encoding, frame length helper.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_OVER = 3'd4
  } spi_state_e;

  localparam logic SPI_WRITE = 1'b1;
  localparam logic SPI_READ  = 1'b0;

  // R/W bit + address field + data field.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Purpose : synchronise one asynchronous pin into clk and flag its edges.
// Latency : level after SYNC_STAGES clk; rise/fall pulses after SYNC_STAGES+1 clk.
// Backpressure: none; pulses are single-cycle and not held.
// Ports: clk, rst_n (async active-low); pin async input;
//   level synchronised value; rise/fall one-cycle registered edge pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Reset value matches the pin's idle level so release from reset
  // never manufactures an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// Purpose : SPI mode-0 peripheral giving write (and optional read) access to NUM_REGS x DATA_W registers.
// Latency : pin edges act SYNC_STAGES+1 clk after the transition; a frame commits SYNC_STAGES+2 clk after nCS rises.
// Backpressure: none; the controller cannot be stalled, so SCLK phases must last >= SYNC_STAGES+2 clk.
// Ports: clk, rst_n (async active-low); nCS/SCLK/COPI SPI inputs; CIPO/cipo_oe SPI output and pad enable;
//   reg_q flattened registers (reg i at [i*DATA_W +: DATA_W]); wr_strobe one-hot update pulse; err rejected-frame pulse.
// Build option: define SPI_READBACK_EN to include the read path; otherwise CIPO/cipo_oe are 0 and reads are rejected.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CMD_LEN   = 1 + ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .pin(nCS),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(SCLK),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .pin(COPI),
    .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  spi_state_e                 state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [FRAME_LEN-1:0]       shift_q;
  logic [FRAME_LEN-1:0]       shift_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]        wr_strobe_q;
  logic                       err_q;

  logic                       frm_wr;
  logic                       frm_rd;
  logic                       frm_addr_ok;
  logic [ADDR_W-1:0]          frm_addr;
  logic [DATA_W-1:0]          frm_dat;
  logic                       sclk_rise_act;

  assign shift_d       = {shift_q[FRAME_LEN-2:0], copi_lvl};
  // Fields of a complete frame, valid while in DONE.
  assign frm_wr        = (shift_q[FRAME_LEN-1] == SPI_WRITE);
  assign frm_rd        = (shift_q[FRAME_LEN-1] == SPI_READ);
  assign frm_addr      = shift_q[DATA_W +: ADDR_W];
  assign frm_dat       = shift_q[DATA_W-1:0];
  // Extra bit so NUM_REGS == 2**ADDR_W does not wrap to zero.
  assign frm_addr_ok   = ({1'b0, frm_addr} < (ADDR_W+1)'(NUM_REGS));
  assign sclk_rise_act = sclk_rise & ~ncs_lvl;

  // Frame FSM. nCS rise takes priority over everything, including an
  // SCLK edge detected in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      regs_q      <= '0;
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
      if (ncs_rise) begin
        state_q <= ST_IDLE;
        case (state_q)
          ST_DONE: begin
            if (frm_wr) begin
              if (frm_addr_ok) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (frm_addr == ADDR_W'(i)) begin
                    regs_q[i*DATA_W +: DATA_W] <= frm_dat;
                    wr_strobe_q[i]             <= 1'b1;
                  end
                end
              end else begin
                err_q <= 1'b1;
              end
            end else if (frm_rd) begin
`ifndef SPI_READBACK_EN
              // No read path in this build: a read is an unusable frame.
              err_q <= 1'b1;
`endif
            end
          end
          // A frame with zero bits is a bare nCS blip and is ignored.
          ST_CMD, ST_DATA: err_q <= (cnt_q != '0);
          ST_OVER:         err_q <= 1'b1;
          default: ;
        endcase
      end else if (ncs_fall) begin
        state_q <= ST_CMD;
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (sclk_rise_act) begin
        case (state_q)
          ST_CMD: begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CMD_LEN-1)) state_q <= ST_DATA;
          end
          ST_DATA: begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_LEN-1)) state_q <= ST_DONE;
          end
          ST_DONE: state_q <= ST_OVER;
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] sout_q;
  logic [DATA_W-1:0] rd_dat;
  logic              oe_q;
  logic              cmd_rd;

  // Bits just completed by the current SCLK rise: {rw, addr}.
  assign cmd_rd = (shift_d[ADDR_W] == SPI_READ);

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_d[ADDR_W-1:0] == ADDR_W'(i)) rd_dat = regs_q[i*DATA_W +: DATA_W];
    end
  end

  // The first SCLK fall of the data phase precedes the controller's
  // sampling of the MSB, so shifting starts only after one data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout_q <= '0;
      oe_q   <= 1'b0;
    end else if (ncs_rise || ncs_fall) begin
      sout_q <= '0;
      oe_q   <= 1'b0;
    end else if (sclk_rise_act) begin
      if (state_q == ST_CMD && cnt_q == CNT_W'(CMD_LEN-1) && cmd_rd) begin
        sout_q <= rd_dat;
        oe_q   <= 1'b1;
      end
    end else if (sclk_fall && state_q == ST_DATA && cnt_q > CNT_W'(CMD_LEN)) begin
      sout_q <= {sout_q[DATA_W-2:0], 1'b0};
    end
  end

  assign CIPO    = oe_q & sout_q[DATA_W-1];
  assign cipo_oe = oe_q;
`else
  logic sclk_fall_unused;
  assign sclk_fall_unused = sclk_fall;
  assign CIPO             = 1'b0;
  assign cipo_oe          = 1'b0;
`endif

  assign reg_q     = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Purpose : self-checking bench for spi_regfile_peripheral against a frame-level register model.
// Latency : checks commit timing of SYNC_STAGES+2 clk after nCS rises.
// Backpressure: n/a; the bench acts as the SPI controller.
module tb_spi_regfile_peripheral;

  localparam int NUM_REGS    = 5;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CMD_LEN     = 1 + ADDR_W;
  localparam int FRAME_LEN   = 1 + ADDR_W + DATA_W;
  localparam int HALF        = 8;
  localparam int TAIL        = 12;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                       clk;
  logic                       rst_n;
  logic                       nCS;
  logic                       SCLK;
  logic                       COPI;
  logic                       CIPO;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]        wr_strobe;
  logic                       err;

  spi_regfile_peripheral #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
    .CIPO(CIPO), .cipo_oe(cipo_oe), .reg_q(reg_q), .wr_strobe(wr_strobe), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [DATA_W-1:0]   mdl [NUM_REGS];
  int                  n_checks;
  int                  n_errors;
  int                  err_pulses;
  int                  strb_pulses;
  logic [NUM_REGS-1:0] strb_last;
  int                  frame_id;

  always @(negedge clk) begin
    if (err) err_pulses++;
    if (wr_strobe != '0) begin
      strb_pulses++;
      strb_last = wr_strobe;
    end
  end

  task automatic check(input string tag_s, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag_s, act, exp);
    end
  endtask

  function automatic string tag(input string s);
    return $sformatf("f%0d_%s", frame_id, s);
  endfunction

  function automatic logic [NUM_REGS*DATA_W-1:0] mdl_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = mdl[i];
    return f;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of frm (MSB-first from bit 31); capture CIPO/cipo_oe at the
  // SCLK rising edges of the data phase, as a mode-0 controller would.
  task automatic shift_bits(input int nbits, input logic [31:0] frm,
                            output logic [DATA_W-1:0] rd, output logic oe_all);
    rd     = '0;
    oe_all = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      COPI = frm[31-b];
      wait_clk(HALF);
      SCLK = 1'b1;
      if (b >= CMD_LEN && b < FRAME_LEN) begin
        rd     = {rd[DATA_W-2:0], CIPO};
        oe_all = oe_all & cipo_oe;
      end
      wait_clk(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input int nbits, input logic [31:0] frm);
    logic              rw;
    int                addr;
    logic [DATA_W-1:0] dat;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] exp_rd;
    logic              oe_all;
    bit                full;
    bit                exp_wr;
    bit                exp_err;
    int                eb;
    int                sb;
    int                lat;
    rw      = frm[31];
    addr    = int'(frm[30:24]);
    dat     = frm[23:16];
    full    = (nbits == FRAME_LEN);
    exp_wr  = full && rw && (addr < NUM_REGS);
    exp_err = (nbits != 0) && !exp_wr && !(full && !rw && RB);
    exp_rd  = '0;
    if (addr < NUM_REGS) exp_rd = mdl[addr];
    eb = err_pulses;
    sb = strb_pulses;

    nCS = 1'b0;
    wait_clk(HALF);
    shift_bits(nbits, frm, rd, oe_all);
    wait_clk(HALF);
    nCS = 1'b1;
    lat = 0;
    for (int k = 1; k <= TAIL; k++) begin
      wait_clk(1);
      if (lat == 0 && (err || wr_strobe != '0)) lat = k;
    end

    if (exp_wr) mdl[addr] = dat;
    frame_id++;
    check(tag("err_n"), err_pulses - eb, exp_err);
    check(tag("strb_n"), strb_pulses - sb, exp_wr);
    if (exp_wr) check(tag("strb"), strb_last, 1 << addr);
    if (exp_wr || exp_err) check(tag("lat"), lat, SYNC_STAGES + 2);
    check(tag("regs"), reg_q, mdl_flat());
    check(tag("cipo_idle"), {cipo_oe, CIPO}, 0);
    if (full && !rw) begin
      check(tag("rd"), rd, RB ? exp_rd : 8'h00);
      check(tag("oe"), oe_all, RB);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic              oe;
    int                eb;
    int                nbits;
    int                r;
    logic [31:0]       frm;

    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    rst_n = 1'b0;
    nCS   = 1'b1;
    SCLK  = 1'b0;
    COPI  = 1'b0;
    wait_clk(4);
    check("rst_regs", reg_q, 0);
    check("rst_strb", wr_strobe, 0);
    check("rst_err", err, 0);
    check("rst_cipo", CIPO, 0);
    check("rst_oe", cipo_oe, 0);
    rst_n = 1'b1;
    wait_clk(TAIL);

    run_frame(16, {1'b1, 7'd4, 8'hA5, 16'h0000});
    run_frame(15, {1'b1, 7'd1, 8'h3C, 16'h0000});
    run_frame(16, {1'b1, 7'd1, 8'h3C, 16'h0000});
    run_frame(16, {1'b1, 7'd2, 8'h3C, 16'h0000});
    run_frame(16, {1'b0, 7'd2, 8'h00, 16'h0000});
    run_frame(16, {1'b0, 7'd6, 8'h00, 16'h0000});
    run_frame(16, {1'b1, 7'd7, 8'h5A, 16'h0000});
    run_frame(17, {1'b1, 7'd3, 8'h11, 16'h8000});
    run_frame(0,  {1'b1, 7'd0, 8'h22, 16'h0000});

    // Reset in the middle of a write frame.
    eb  = err_pulses;
    nCS = 1'b0;
    wait_clk(HALF);
    shift_bits(9, {1'b1, 7'd3, 8'h77, 16'h0000}, rd, oe);
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst_regs", reg_q, 0);
    check("midrst_strb", wr_strobe, 0);
    check("midrst_err", err, 0);
    check("midrst_cipo", {cipo_oe, CIPO}, 0);
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    nCS = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(TAIL);
    check("midrst_err_n", err_pulses - eb, 0);
    run_frame(16, {1'b1, 7'd0, 8'hFF, 16'h0000});

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        5:       nbits = 0;
        6:       nbits = 15;
        7:       nbits = 17;
        8, 9:    nbits = int'($urandom_range(1, 20));
        default: nbits = 16;
      endcase
      frm        = $urandom;
      frm[30:24] = 7'($urandom_range(0, 7));
      run_frame(nbits, frm);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
